sobel_avalon_master: RTL and testbench

// - Avalon-MM master between the sobel_edge_detection core and system memory.
// - Serves the core's pixel reads: read_enable plus a 32-bit address in, read_word plus a data_ready pulse out.
// - Buffers the core's output-pixel writes in a small FIFO and drains them to memory.
// - Arbitrates read and write traffic onto a single Avalon port, with one transaction outstanding at a time.

---
 rtl/sobel_avalon_master.sv | 181 ++++++++++++++++++
 tb/tb_sobel_avalon_master.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_avalon_master.sv
// Avalon-MM master for the Sobel core: serves pixel reads and drains buffered
// output-pixel writes through one bus port, one transaction outstanding at a time.
module sobel_avalon_master #(
    parameter int WBUF_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] pix_address,
    input  logic              write_out_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [31:0]       sobel_pixel,
    output logic [31:0]       read_word,
    output logic              data_ready,
    output logic              wbuf_full,
    output logic              writes_idle,
    output logic              wr_overflow,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] WR_REQ  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rword_q, rword_d;
    logic              dready_q, dready_d;
    logic              ovf_q, ovf_d;

    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [31:0]       wb_data_q [WBUF_DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic full;
    logic push;
    logic pop;

    assign full = (count_q == FULL_CNT);
    // A strobe while full is dropped even if the head pops this cycle.
    assign push = write_out_enable && !full;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        rword_d  = rword_q;
        dready_d = 1'b0;
        ovf_d    = ovf_q | (write_out_enable && full);
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (full) begin
                    state_d = WR_REQ;
                    wr_d    = 1'b1;
                    addr_d  = wb_addr_q[rptr_q];
                    wdata_d = wb_data_q[rptr_q];
                end else if (read_enable && !dready_q) begin
                    state_d = RD_REQ;
                    rd_d    = 1'b1;
                    addr_d  = pix_address;
                end else if (count_q != '0) begin
                    state_d = WR_REQ;
                    wr_d    = 1'b1;
                    addr_d  = wb_addr_q[rptr_q];
                    wdata_d = wb_data_q[rptr_q];
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = RD_WAIT;
                    rd_d    = 1'b0;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rword_d  = avm_readdata;
                    dready_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    pop     = 1'b1;
                    wr_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[wptr_q] <= write_addr;
            wb_data_q[wptr_q] <= sobel_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rword_q  <= '0;
            dready_q <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rword_q  <= rword_d;
            dready_q <= dready_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end

    assign read_word      = rword_q;
    assign data_ready     = dready_q;
    assign wbuf_full      = full;
    assign writes_idle    = (count_q == '0) && (state_q != WR_REQ);
    assign wr_overflow    = ovf_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_sobel_avalon_master.sv
// Scoreboard bench for sobel_avalon_master: a bus-slave model records accepted
// transfers and read completions; each test compares them with expected queues.
module tb_sobel_avalon_master;

    logic        clk;
    logic        rst;
    logic        read_enable;
    logic [31:0] pix_address;
    logic        write_out_enable;
    logic [31:0] write_addr;
    logic [31:0] sobel_pixel;
    logic [31:0] read_word;
    logic        data_ready;
    logic        wbuf_full;
    logic        writes_idle;
    logic        wr_overflow;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    sobel_avalon_master #(.WBUF_DEPTH(4), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .read_enable       (read_enable),
        .pix_address       (pix_address),
        .write_out_enable  (write_out_enable),
        .write_addr        (write_addr),
        .sobel_pixel       (sobel_pixel),
        .read_word         (read_word),
        .data_ready        (data_ready),
        .wbuf_full         (wbuf_full),
        .writes_idle       (writes_idle),
        .wr_overflow       (wr_overflow),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] exp_wr_q [$];
    logic [63:0] obs_wr_q [$];
    logic [31:0] exp_rd_q [$];
    logic [31:0] obs_rd_q [$];
    byte         log_q    [$];

    int          rd_latency   = 1;
    int          rd_cnt       = 0;
    logic        rd_pending   = 1'b0;
    logic [31:0] rd_addr      = '0;
    int          rd_hi_cycles = 0;
    int          wr_hi_cycles = 0;
    int          rd_issues    = 0;
    int          dr_pulses    = 0;
    int          both_hi      = 0;
    int          stab_viol    = 0;
    logic        prev_hold    = 1'b0;
    logic [65:0] prev_bus     = '0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hA5A5_A5A5;
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // One clock of slave behaviour: observe at negedge, respond 1 ns after posedge.
    task automatic cycle();
        logic [65:0] bus;
        @(negedge clk);
        bus = {avm_read, avm_write, avm_address, avm_writedata};
        if (prev_hold && bus != prev_bus) stab_viol++;
        prev_hold = !rst && avm_waitrequest && (avm_read || avm_write);
        prev_bus  = bus;
        if (avm_read && avm_write) both_hi++;
        if (avm_read) rd_hi_cycles++;
        if (avm_write) wr_hi_cycles++;
        if (data_ready) begin
            dr_pulses++;
            obs_rd_q.push_back(read_word);
        end
        if (!rst && avm_write && !avm_waitrequest) begin
            obs_wr_q.push_back({avm_address, avm_writedata});
            log_q.push_back("W");
        end
        if (!rst && avm_read && !avm_waitrequest) begin
            rd_addr    = avm_address;
            rd_cnt     = rd_latency;
            rd_pending = 1'b1;
            rd_issues++;
            log_q.push_back("R");
        end
        @(posedge clk);
        #1;
        avm_readdatavalid = 1'b0;
        if (rd_pending) begin
            if (rd_cnt <= 1) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rd_model(rd_addr);
                rd_pending        = 1'b0;
            end else begin
                rd_cnt--;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        total_cnt++; if (avm_read !== 1'b0) $display("FAIL reset_avm_read got=%b exp=0", avm_read); else pass_cnt++;
        total_cnt++; if (avm_write !== 1'b0) $display("FAIL reset_avm_write got=%b exp=0", avm_write); else pass_cnt++;
        total_cnt++; if (data_ready !== 1'b0) $display("FAIL reset_data_ready got=%b exp=0", data_ready); else pass_cnt++;
        total_cnt++; if (wr_overflow !== 1'b0) $display("FAIL reset_wr_overflow got=%b exp=0", wr_overflow); else pass_cnt++;
        total_cnt++; if (avm_address !== 32'h0) $display("FAIL reset_avm_address got=%h exp=0", avm_address); else pass_cnt++;
        total_cnt++; if (avm_writedata !== 32'h0) $display("FAIL reset_writedata got=%h exp=0", avm_writedata); else pass_cnt++;
        total_cnt++; if (read_word !== 32'h0) $display("FAIL reset_read_word got=%h exp=0", read_word); else pass_cnt++;
        total_cnt++; if (wbuf_full !== 1'b0) $display("FAIL reset_wbuf_full got=%b exp=0", wbuf_full); else pass_cnt++;
        total_cnt++; if (writes_idle !== 1'b1) $display("FAIL reset_writes_idle got=%b exp=1", writes_idle); else pass_cnt++;
        total_cnt++; if (avm_byteenable !== 4'hF) $display("FAIL byteenable got=%h exp=f", avm_byteenable); else pass_cnt++;
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_read_zero_wait();
        int lat;
        int rh0;
        int dr0;
        logic [31:0] e;
        rd_latency      = 1;
        avm_waitrequest = 1'b0;
        rh0 = rd_hi_cycles;
        dr0 = dr_pulses;
        pix_address = 32'h0000_1000;
        read_enable = 1'b1;
        exp_rd_q.push_back(32'hA5A5_A5A5);
        lat = 0;
        while (obs_rd_q.size() == 0 && lat < 20) begin
            cycle();
            lat++;
        end
        read_enable = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        total_cnt++; if (lat !== 4) $display("FAIL read_latency got=%0d exp=4", lat); else pass_cnt++;
        total_cnt++; if (rd_addr !== 32'h0000_1000) $display("FAIL read_address got=%h exp=00001000", rd_addr); else pass_cnt++;
        total_cnt++; if (rd_hi_cycles - rh0 !== 1) $display("FAIL read_strobe_cycles got=%0d exp=1", rd_hi_cycles - rh0); else pass_cnt++;
        total_cnt++; if (dr_pulses - dr0 !== 1) $display("FAIL data_ready_pulses got=%0d exp=1", dr_pulses - dr0); else pass_cnt++;
        e = exp_rd_q.pop_front();
        total_cnt++;
        if (obs_rd_q.size() == 0) $display("FAIL read_word_zero_wait got=none exp=%h", e);
        else if (obs_rd_q[0] !== e) $display("FAIL read_word_zero_wait got=%h exp=%h", obs_rd_q[0], e);
        else pass_cnt++;
        obs_rd_q.delete();
        log_q.delete();
    endtask

    task automatic test_waitrequest();
        int rh0;
        int wh0;
        int ri0;
        int n;
        logic [31:0] e;
        logic [63:0] ew;
        rh0 = rd_hi_cycles;
        ri0 = rd_issues;
        avm_waitrequest = 1'b1;
        pix_address = 32'h0000_2000;
        read_enable = 1'b1;
        exp_rd_q.push_back(rd_model(32'h0000_2000));
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        avm_waitrequest = 1'b0;
        n = 0;
        while (obs_rd_q.size() == 0 && n < 20) begin
            cycle();
            n++;
        end
        read_enable = 1'b0;
        cycle();
        total_cnt++; if (rd_hi_cycles - rh0 !== 4) $display("FAIL wait_read_strobe got=%0d exp=4", rd_hi_cycles - rh0); else pass_cnt++;
        total_cnt++; if (rd_issues - ri0 !== 1) $display("FAIL wait_read_transfers got=%0d exp=1", rd_issues - ri0); else pass_cnt++;
        e = exp_rd_q.pop_front();
        total_cnt++;
        if (obs_rd_q.size() != 1) $display("FAIL wait_read_data got=%0d_results exp=1", obs_rd_q.size());
        else if (obs_rd_q[0] !== e) $display("FAIL wait_read_data got=%h exp=%h", obs_rd_q[0], e);
        else pass_cnt++;
        obs_rd_q.delete();

        wh0 = wr_hi_cycles;
        avm_waitrequest  = 1'b1;
        write_out_enable = 1'b1;
        write_addr       = 32'h0000_3000;
        sobel_pixel      = 32'hCAFE_0001;
        exp_wr_q.push_back({32'h0000_3000, 32'hCAFE_0001});
        cycle();
        write_out_enable = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        avm_waitrequest = 1'b0;
        cycle();
        cycle();
        total_cnt++; if (wr_hi_cycles - wh0 !== 4) $display("FAIL wait_write_strobe got=%0d exp=4", wr_hi_cycles - wh0); else pass_cnt++;
        ew = exp_wr_q.pop_front();
        total_cnt++;
        if (obs_wr_q.size() != 1) $display("FAIL wait_write_transfers got=%0d exp=1", obs_wr_q.size());
        else if (obs_wr_q[0] !== ew) $display("FAIL wait_write_data got=%h exp=%h", obs_wr_q[0], ew);
        else pass_cnt++;
        obs_wr_q.delete();
        log_q.delete();
    endtask

    task automatic test_fifo_full();
        int n;
        logic [63:0] ew;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_out_enable = 1'b1;
            write_addr  = 32'h0000_4000 + 32'(i * 4);
            sobel_pixel = 32'(8'h11 * (i + 1));
            exp_wr_q.push_back({write_addr, sobel_pixel});
            cycle();
            if (i == 2) begin
                total_cnt++; if (wbuf_full !== 1'b0) $display("FAIL full_after_3 got=%b exp=0", wbuf_full); else pass_cnt++;
            end
        end
        total_cnt++; if (wbuf_full !== 1'b1) $display("FAIL full_after_4 got=%b exp=1", wbuf_full); else pass_cnt++;
        total_cnt++; if (wr_overflow !== 1'b0) $display("FAIL overflow_before_5th got=%b exp=0", wr_overflow); else pass_cnt++;
        write_addr  = 32'h0000_4010;
        sobel_pixel = 32'h0000_0055;
        cycle();
        write_out_enable = 1'b0;
        total_cnt++; if (wr_overflow !== 1'b1) $display("FAIL overflow_on_5th got=%b exp=1", wr_overflow); else pass_cnt++;
        avm_waitrequest = 1'b0;
        n = 0;
        while (obs_wr_q.size() < 4 && n < 40) begin
            cycle();
            n++;
        end
        for (int i = 0; i < 3; i++) cycle();
        total_cnt++; if (obs_wr_q.size() !== 4) $display("FAIL full_drain_count got=%0d exp=4", obs_wr_q.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            ew = exp_wr_q.pop_front();
            total_cnt++;
            if (obs_wr_q.size() == 0) $display("FAIL full_drain_order[%0d] got=none exp=%h", i, ew);
            else if (obs_wr_q[0] !== ew) $display("FAIL full_drain_order[%0d] got=%h exp=%h", i, obs_wr_q[0], ew);
            else pass_cnt++;
            if (obs_wr_q.size() != 0) void'(obs_wr_q.pop_front());
        end
        total_cnt++; if (wr_overflow !== 1'b1) $display("FAIL overflow_sticky got=%b exp=1", wr_overflow); else pass_cnt++;
        total_cnt++; if (writes_idle !== 1'b1) $display("FAIL idle_after_drain got=%b exp=1", writes_idle); else pass_cnt++;
        total_cnt++; if (wbuf_full !== 1'b0) $display("FAIL full_after_drain got=%b exp=0", wbuf_full); else pass_cnt++;
        obs_wr_q.delete();
        exp_wr_q.delete();
        log_q.delete();
    endtask

    task automatic check_arb(input string name, input string exp_order);
        string got;
        logic [31:0] e;
        logic [63:0] ew;
        got = "";
        foreach (log_q[i]) got = {got, string'(log_q[i])};
        total_cnt++; if (got != exp_order) $display("FAIL %s_order got=%s exp=%s", name, got, exp_order); else pass_cnt++;
        while (exp_rd_q.size() != 0) begin
            e = exp_rd_q.pop_front();
            total_cnt++;
            if (obs_rd_q.size() == 0) $display("FAIL %s_read got=none exp=%h", name, e);
            else if (obs_rd_q[0] !== e) $display("FAIL %s_read got=%h exp=%h", name, obs_rd_q[0], e);
            else pass_cnt++;
            if (obs_rd_q.size() != 0) void'(obs_rd_q.pop_front());
        end
        while (exp_wr_q.size() != 0) begin
            ew = exp_wr_q.pop_front();
            total_cnt++;
            if (obs_wr_q.size() == 0) $display("FAIL %s_write got=none exp=%h", name, ew);
            else if (obs_wr_q[0] !== ew) $display("FAIL %s_write got=%h exp=%h", name, obs_wr_q[0], ew);
            else pass_cnt++;
            if (obs_wr_q.size() != 0) void'(obs_wr_q.pop_front());
        end
        obs_rd_q.delete();
        obs_wr_q.delete();
        log_q.delete();
    endtask

    task automatic test_arbitration();
        int n;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        avm_waitrequest = 1'b0;
        rd_latency = 1;
        write_out_enable = 1'b1;
        write_addr  = 32'h0000_5000;
        sobel_pixel = 32'h0000_0A01;
        exp_wr_q.push_back({32'h0000_5000, 32'h0000_0A01});
        cycle();
        write_addr  = 32'h0000_5004;
        sobel_pixel = 32'h0000_0A02;
        exp_wr_q.push_back({32'h0000_5004, 32'h0000_0A02});
        pix_address = 32'h0000_5100;
        read_enable = 1'b1;
        exp_rd_q.push_back(rd_model(32'h0000_5100));
        cycle();
        write_out_enable = 1'b0;
        n = 0;
        while ((obs_rd_q.size() < 1 || obs_wr_q.size() < 2) && n < 40) begin
            cycle();
            if (obs_rd_q.size() >= 1) read_enable = 1'b0;
            n++;
        end
        read_enable = 1'b0;
        cycle();
        check_arb("arb_read_first", "RWW");

        rd_latency  = 6;
        pix_address = 32'h0000_6000;
        read_enable = 1'b1;
        exp_rd_q.push_back(rd_model(32'h0000_6000));
        n = 0;
        while (log_q.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            write_out_enable = 1'b1;
            write_addr  = 32'h0000_7000 + 32'(i * 4);
            sobel_pixel = 32'h0000_0B00 + 32'(i);
            exp_wr_q.push_back({write_addr, sobel_pixel});
            cycle();
        end
        write_out_enable = 1'b0;
        exp_rd_q.push_back(rd_model(32'h0000_6100));
        n = 0;
        while ((obs_rd_q.size() < 2 || obs_wr_q.size() < 4) && n < 60) begin
            cycle();
            if (obs_rd_q.size() == 1) pix_address = 32'h0000_6100;
            if (obs_rd_q.size() >= 2) read_enable = 1'b0;
            n++;
        end
        read_enable = 1'b0;
        cycle();
        check_arb("arb_full_first", "RWRWWW");
    endtask

    task automatic test_reset_mid_read();
        int dr0;
        int n;
        rd_latency = 3;
        avm_waitrequest = 1'b0;
        dr0 = dr_pulses;
        pix_address = 32'h0000_8000;
        read_enable = 1'b1;
        n = 0;
        while (log_q.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        write_out_enable = 1'b1;
        write_addr  = 32'h0000_9000;
        sobel_pixel = 32'h0000_0C01;
        cycle();
        write_out_enable = 1'b0;
        read_enable = 1'b0;
        rst = 1'b1;
        cycle();
        total_cnt++; if (avm_read !== 1'b0 || avm_write !== 1'b0) $display("FAIL midrst_strobes got=%b%b exp=00", avm_read, avm_write); else pass_cnt++;
        total_cnt++; if (writes_idle !== 1'b1) $display("FAIL midrst_writes_idle got=%b exp=1", writes_idle); else pass_cnt++;
        total_cnt++; if (wbuf_full !== 1'b0) $display("FAIL midrst_wbuf_full got=%b exp=0", wbuf_full); else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        total_cnt++; if (dr_pulses - dr0 !== 0) $display("FAIL midrst_data_ready got=%0d exp=0", dr_pulses - dr0); else pass_cnt++;
        total_cnt++; if (obs_wr_q.size() !== 0) $display("FAIL midrst_flushed_writes got=%0d exp=0", obs_wr_q.size()); else pass_cnt++;
        total_cnt++; if (avm_read !== 1'b0) $display("FAIL midrst_no_reissue got=%b exp=0", avm_read); else pass_cnt++;
        obs_wr_q.delete();
        obs_rd_q.delete();
        log_q.delete();
    endtask

    task automatic test_bus_rules();
        total_cnt++; if (both_hi !== 0) $display("FAIL read_write_both_high got=%0d exp=0", both_hi); else pass_cnt++;
        total_cnt++; if (stab_viol !== 0) $display("FAIL bus_stable_under_wait got=%0d exp=0", stab_viol); else pass_cnt++;
    endtask

    initial begin
        rst               = 1'b1;
        read_enable       = 1'b0;
        pix_address       = '0;
        write_out_enable  = 1'b0;
        write_addr        = '0;
        sobel_pixel       = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_waitrequest();
        test_fifo_full();
        test_arbitration();
        test_reset_mid_read();
        test_bus_rules();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
